// File: rtl/div_seq_pkg.sv
// Shared state codes and constants for the sequential divider.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_DIVZERO = 2'b01,
        DIV_RUN     = 2'b10,
        DIV_DONE    = 2'b11
    } div_state_e;

    localparam logic [2*DIV_WIDTH-1:0] DIV_ZERO_WORD = '0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider serving DIV/DIVU.
// result_o = {remainder, quotient}, one iteration per clock.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] neg_if(
        input logic [WIDTH-1:0] v,
        input logic             n
    );
        return n ? (~v + 1'b1) : v;
    endfunction

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     shl, diff, rem_n;
    logic [WIDTH-1:0]   quo_n;
    logic               a_neg, b_neg;

    assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg = signed_div_i & opdata2_i[WIDTH-1];

    // One shift-subtract step; remainder stays below divisor so WIDTH+1 bits suffice.
    always_comb begin
        shl  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff = shl - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_n = diff;
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shl;
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    dvs_d   = neg_if(opdata2_i, b_neg);
                    quo_d   = neg_if(opdata1_i, a_neg);
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = (opdata2_i == '0) ? DIV_DIVZERO : DIV_RUN;
                end
            end
            DIV_DIVZERO: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d  = DIV_DONE;
                    ready_d  = 1'b1;
                    result_d = DIV_ZERO_WORD;
                end
            end
            DIV_RUN: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = DIV_DONE;
                        ready_d  = 1'b1;
                        result_d = {neg_if(rem_n[WIDTH-1:0], rneg_q),
                                    neg_if(quo_n, qneg_q)};
                    end
                end
            end
            DIV_DONE: begin
                if (annul_i || !start_i) begin
                    state_d  = DIV_IDLE;
                    ready_d  = 1'b0;
                    result_d = DIV_ZERO_WORD;
                end
            end
            default: begin
                state_d  = DIV_IDLE;
                ready_d  = 1'b0;
                result_d = DIV_ZERO_WORD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            result_q <= DIV_ZERO_WORD;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized bench for div_seq against an arithmetic reference.
module tb_div_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          signed_div;
    logic [W-1:0]  op1, op2;
    logic          start, annul;
    logic [2*W-1:0] result;
    logic          ready;

    int total = 0;
    int bad   = 0;

    logic          exp_ready;
    logic [2*W-1:0] exp_result;

    div_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("ready", {63'd0, ready}, {63'd0, exp_ready});
            chk("result", result, exp_result);
        end
    end

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic sgn);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int hold, input int annul_at,
                         input logic use_lit, input logic [2*W-1:0] lit);
        int lat;
        logic [2*W-1:0] want;
        lat  = (b == '0) ? 1 : W;
        want = ref_div(a, b, sgn);
        @(negedge clk);
        op1 = a; op2 = b; signed_div = sgn; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
            end
            if (k == annul_at) annul = 1'b1;
            @(posedge clk);
            if (k == annul_at) begin
                @(negedge clk);
                annul = 1'b0; start = 1'b0;
                @(posedge clk);
                return;
            end
        end
        #1 exp_ready = 1'b1; exp_result = want;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        if (use_lit) chk("literal", result, lit);
        start = 1'b0;
        @(posedge clk);
        #1 exp_ready = 1'b0; exp_result = '0;
    endtask

    task automatic reset_pulse(input int edges_in);
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (edges_in) @(posedge clk);
        if (edges_in > W) begin
            #1 exp_ready = 1'b1; exp_result = 64'h00000002_0000000E;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_result", result, 64'd0);
        start = 1'b0; exp_ready = 1'b0; exp_result = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        op1 = '0; op2 = '0; exp_ready = 1'b0; exp_result = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, 0, 0, 1'b1, 64'h00000002_0000000E);
        do_op(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        do_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0, 1'b1, 64'h00000001_FFFFFFFD);
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, 0, 0, 1'b1, 64'h00000000_FFFFFFFF);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, 1'b1,
              64'h00000000_80000000);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b1,
              64'h80000000_00000000);
        do_op(32'd1234, 32'd0, 1'b0, 0, 0, 1'b1, 64'd0);
        do_op(32'h80000000, 32'd0, 1'b1, 0, 0, 1'b1, 64'd0);
        do_op(32'd100, 32'd7, 1'b0, 0, 10, 1'b0, 64'd0);
        do_op(32'd9, 32'd4, 1'b0, 0, 0, 1'b1, 64'h00000001_00000002);
        do_op(32'd100, 32'd7, 1'b0, 3, 0, 1'b1, 64'h00000002_0000000E);

        @(negedge clk);
        start = 1'b1; annul = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        @(posedge clk);

        reset_pulse(12);
        reset_pulse(W + 1);
        do_op(32'd9, 32'd4, 1'b0, 0, 0, 1'b1, 64'h00000001_00000002);

        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] a, b;
            int lat, ann;
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            lat = (b == '0) ? 1 : W;
            ann = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
            do_op(a, b, 1'($urandom), $urandom_range(0, 2), ann,
                  1'b0, 64'd0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
